// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline register with two-entry skid buffer, flush and saturating stall counter
module pipe_skid_stage #(
   parameter int unsigned WIDTH          = 32,
   parameter bit          CLEAR_ON_FLUSH = 1'b1,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_fire, out_fire;
   // ready is pure state decode so downstream stalls never reach upstream combinationally
   assign in_ready  = (state_q != FULL) && !flush && !reset;
   assign out_valid = state_q != EMPTY;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   assign out_data  = main_q;
   assign occupancy = state_q;
   assign stall_cnt = cnt_q;
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      cnt_d   = (out_valid && !out_ready && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
      if (flush) begin
         state_d = EMPTY;
         main_d  = CLEAR_ON_FLUSH ? '0 : main_q;
         skid_d  = CLEAR_ON_FLUSH ? '0 : skid_q;
      end else begin
         case (state_q)
            EMPTY: begin
               main_d  = in_fire ? in_data : main_q;
               state_d = in_fire ? ONE : EMPTY;
            end
            ONE: begin
               main_d  = (in_fire && out_fire) ? in_data : main_q;
               skid_d  = (in_fire && !out_fire) ? in_data : skid_q;
               state_d = (in_fire && !out_fire) ? FULL : (out_fire && !in_fire) ? EMPTY : ONE;
            end
            FULL: begin
               main_d  = out_fire ? skid_q : main_q;
               state_d = out_fire ? ONE : FULL;
            end
            default: state_d = EMPTY;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed and random checks of two pipe_skid_stage variants against a queue model
module tb_pipe_skid_stage;
   localparam int W = 70;
   logic         clk = 1'b0;
   logic         reset, flush, in_valid, out_ready;
   logic [W-1:0] in_data;
   logic         in_ready1, out_valid1, in_ready0, out_valid0;
   logic [W-1:0] out_data1, out_data0;
   logic [1:0]   occ1, occ0;
   logic [3:0]   cnt1, cnt0;
   int           total = 0, bad = 0;
   logic [W-1:0] q[$];
   int           cnt = 0;
   always #5 clk = ~clk;
   pipe_skid_stage #(.WIDTH(W), .CLEAR_ON_FLUSH(1'b1), .CNT_W(4)) dut1 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
      .occupancy(occ1), .stall_cnt(cnt1));
   pipe_skid_stage #(.WIDTH(W), .CLEAR_ON_FLUSH(1'b0), .CNT_W(4)) dut0 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
      .occupancy(occ0), .stall_cnt(cnt0));
   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // one clock: drive at negedge, compare against the FIFO model, then advance the model past posedge
   task automatic cyc(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl, input logic rs);
      logic rdy;
      in_valid = iv; in_data = d; out_ready = ordy; flush = fl; reset = rs;
      #1;
      rdy = q.size() < 2 && !fl && !rs;
      chk("in_ready1", W'(in_ready1), W'(rdy));
      chk("in_ready0", W'(in_ready0), W'(rdy));
      chk("out_valid1", W'(out_valid1), W'(q.size() > 0));
      chk("out_valid0", W'(out_valid0), W'(q.size() > 0));
      chk("occ1", W'(occ1), W'(q.size()));
      chk("occ0", W'(occ0), W'(q.size()));
      chk("stall1", W'(cnt1), W'(cnt));
      chk("stall0", W'(cnt0), W'(cnt));
      if (q.size() > 0) begin
         chk("data1", out_data1, q[0]);
         chk("data0", out_data0, q[0]);
      end
      out_ready = !ordy;
      #1;
      chk("rdy_indep", W'(in_ready1), W'(rdy));
      out_ready = ordy;
      @(posedge clk);
      if (rs) begin
         q.delete();
         cnt = 0;
      end else begin
         if (q.size() > 0 && !ordy && cnt < 15) cnt++;
         if (fl) q.delete();
         else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (iv && rdy) q.push_back(d);
         end
      end
      @(negedge clk);
   endtask
   initial begin
      in_valid = 0; in_data = '0; out_ready = 0; flush = 0; reset = 1;
      @(posedge clk);
      @(negedge clk);
      cyc(0, 0, 0, 0, 1);
      chk("rst_data1", out_data1, '0);
      chk("rst_data0", out_data0, '0);
      // streaming
      cyc(1, 70'h1, 1, 0, 0);
      cyc(1, 70'h2, 1, 0, 0);
      cyc(1, 70'h3, 1, 0, 0);
      chk("stream_occ", W'(occ1), W'(1));
      cyc(0, 0, 1, 0, 0);
      // backpressure
      cyc(1, 70'hA, 1, 0, 0);
      cyc(1, 70'hB, 0, 0, 0);
      chk("bp_occ", W'(occ1), W'(2));
      chk("bp_rdy", W'(in_ready1), W'(0));
      cyc(1, 70'hC, 0, 0, 0);
      cyc(1, 70'hC, 0, 0, 0);
      cyc(1, 70'hC, 1, 0, 0);
      chk("bp_b", out_data1, 70'hB);
      cyc(1, 70'hC, 1, 0, 0);
      chk("bp_c", out_data1, 70'hC);
      cyc(0, 0, 1, 0, 0);
      chk("bp_stall", W'(cnt1), W'(3));
      // flush while full
      cyc(1, 70'h5, 0, 0, 0);
      cyc(1, 70'h6, 0, 0, 0);
      cyc(1, 70'hD, 0, 1, 0);
      chk("fl_data1", out_data1, '0);
      chk("fl_data0", out_data0, 70'h5);
      chk("fl_valid", W'(out_valid0), W'(0));
      chk("fl_occ", W'(occ0), W'(0));
      chk("fl_stall", W'(cnt1), W'(5));
      cyc(1, 70'h7, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);
      // flush and reset together
      cyc(1, 70'h8, 0, 0, 0);
      cyc(1, 70'h9, 0, 0, 0);
      cyc(1, 70'hE, 0, 1, 1);
      chk("rf_data1", out_data1, '0);
      chk("rf_data0", out_data0, '0);
      chk("rf_stall", W'(cnt0), W'(0));
      chk("rf_occ", W'(occ1), W'(0));
      // saturation
      cyc(1, 70'h1, 0, 0, 0);
      for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0);
      chk("sat", W'(cnt1), W'(4'hF));
      cyc(0, 0, 0, 1, 0);
      chk("sat_fl", W'(cnt0), W'(4'hF));
      cyc(0, 0, 0, 0, 1);
      // random stress
      for (int i = 0; i < 3000; i++)
         cyc($urandom % 4 != 0, {$urandom, $urandom, $urandom}, $urandom % 3 != 0, $urandom % 50 == 0, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline stage register for the five-stage core. It generalises the per-stage register pair (decode-to-execute, execute-to-memory, …) into one valid/ready stage with a two-entry skid buffer, synchronous flush and a stall-cycle counter. Every inter-stage boundary instantiates it with a different payload width. Its backpressure is fully registered, so no combinational path runs from a downstream stall to upstream ready.

## Interface
- WIDTH, 32: payload width in bits (pc, operands, control fields concatenated by the instantiating stage).
- CLEAR_ON_FLUSH, 1: 1 = payload registers zeroed on flush; 0 = payload held, only valid cleared.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous kill of all held entries (branch/exception redirect).
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage accepts a payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data is a live instruction.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  WIDTH  payload presented downstream.
- occupancy  out  2  entries held (0, 1 or 2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

## Operation
- Storage: main register (drives out_data) and skid register.
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready.
- in_ready = (state != FULL) & !flush & !reset. It depends on no other input.
- State machine, three states:
  - EMPTY: out_valid=0. in_fire -> main<=in_data, go ONE.
  - ONE: out_valid=1.
    - in_fire & out_fire -> main<=in_data, stay ONE.
    - in_fire only -> skid<=in_data, go FULL.
    - out_fire only -> go EMPTY.
    - neither -> hold.
  - FULL: out_valid=1, in_ready=0.
    - out_fire -> main<=skid, go ONE.
    - else hold.
- occupancy = 0/1/2 for EMPTY/ONE/FULL.
- Order is strict FIFO: skid contents never overtake main.
- flush, not in reset:
  - state<=EMPTY, out_valid 0 next cycle.
  - Any in_data offered that cycle is dropped (in_ready is 0).
  - An out_fire in the flush cycle still counts as consumed downstream.
  - CLEAR_ON_FLUSH=1: main and skid <= 0. CLEAR_ON_FLUSH=0: both hold their value.
- stall_cnt:
  - Increments when out_valid & !out_ready.
  - Saturates at all-ones.
  - Cleared only by reset; flush does not clear it.
- Priority: reset > flush > normal transfer.

## Timing
- Reset values:
  - state EMPTY; out_valid 0; out_data 0; skid 0; occupancy 0; stall_cnt 0.
  - in_ready 0 during the reset cycle, 1 the cycle after.
- Latency: in_fire in cycle N into EMPTY or ONE gives out_valid=1 with that data in cycle N+1.
- Throughput: one transfer per cycle sustained while out_ready=1.
- out_ready falling: one extra beat is absorbed by skid; in_ready drops the next cycle.
- out_ready rising in FULL: skid data appears on out_data next cycle; in_ready returns 1 the same next cycle.
- All outputs except in_ready are registered. in_ready is state decode gated by flush/reset.
- Reset or flush mid-FULL discards both entries in one cycle; the next accepted payload emerges with latency 1.

## Test plan
- Streaming: reset, then in_valid=1 with data 0x1,0x2,0x3 on consecutive cycles and out_ready=1 -> out_data 0x1,0x2,0x3 on cycles 1..3 after each; occupancy stays 1; stall_cnt 0.
- Backpressure:
  - Stimulus: send 0xA,0xB,0xC with out_ready=0 from the cycle 0xA appears.
  - Expect: 0xB is captured in skid, occupancy=2, in_ready=0, 0xC is held upstream.
  - Then release out_ready: outputs 0xA,0xB,0xC in order with no duplicate; stall_cnt equals the number of stalled cycles.
- Flush while FULL with CLEAR_ON_FLUSH=1 and in_valid=1 (data 0xD):
  - Next cycle: out_valid=0, out_data=0, occupancy=0; 0xD not accepted.
  - Same test with CLEAR_ON_FLUSH=0: out_data still shows the old main value with out_valid=0.
- Simultaneous flush and reset: reset wins, all outputs at reset values; stall_cnt 0.
- Counter saturation, CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reaches 0xF and holds; a subsequent flush leaves it at 0xF.
- Random valid/ready stress with WIDTH=70: scoreboard confirms in-order, lossless, duplicate-free transfer; in_ready never depends on out_ready in the same cycle.
